// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronises A/B, tracks phase, emits up/down step pulses and counts illegal transitions.
// Optional glitch filter between synchroniser and FSM is enabled by defining QDEC_FILTER_EN.
module quadrature_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 clear_err,
  output logic                 up,
  output logic                 down,
  output logic                 dir,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {INIT, P00, P01, P11, P10} state_t;

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             p;
  logic [1:0]             cur;
  state_t                 state_q;
  logic                   up_q, down_q, dir_q, err_q;
  logic [ERR_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]         sync_s;
  logic [1:0]         acc_q;
  logic [1:0][CW-1:0] run_q;

  assign sync_s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  // A level is accepted on the FILTER_LEN-th consecutive cycle it differs from the accepted one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      run_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_s[i] == acc_q[i]) begin
          run_q[i] <= '0;
        end else if (run_q[i] == CW'(FILTER_LEN - 1)) begin
          acc_q[i] <= sync_s[i];
          run_q[i] <= '0;
        end else begin
          run_q[i] <= run_q[i] + 1'b1;
        end
      end
    end
  end

  assign p = acc_q;
`else
  assign p = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
`endif

  function automatic state_t phase_state(input logic [1:0] ph);
    case (ph)
      2'b00:   return P00;
      2'b01:   return P01;
      2'b11:   return P11;
      default: return P10;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      P01:     cur = 2'b01;
      P11:     cur = 2'b11;
      P10:     cur = 2'b10;
      default: cur = 2'b00;
    endcase
  end

  assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      if (clear_err) begin
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end
      if (!enable) begin
        state_q <= INIT;
      end else if (state_q == INIT) begin
        state_q <= phase_state(p);
      end else if (p != cur) begin
        state_q <= phase_state(p);
        case ({cur, p})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
            up_q  <= 1'b1;
            dir_q <= 1'b1;
          end
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
            down_q <= 1'b1;
            dir_q  <= 1'b0;
          end
          default: begin
            // Both bits flipped: a phase was skipped.
            err_q     <= 1'b1;
            err_cnt_q <= clear_err ? ERR_WIDTH'(1) : err_cnt_d;
          end
        endcase
      end
    end
  end

  assign up        = up_q;
  assign down      = down_q;
  assign dir       = dir_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: phase-position model checked every cycle plus directed literal checks.
module tb_quadrature_decoder;

  localparam int S    = 2;
  localparam int FL   = 4;
  localparam int EW   = 8;
  localparam int EMAX = (1 << EW) - 1;
`ifdef QDEC_FILTER_EN
  localparam int LAT  = S + FL;
`else
  localparam int LAT  = S;
`endif
  localparam int STEP = LAT + 6;
  localparam int FLIP = LAT + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic a_in = 1'b1;
  logic b_in = 1'b1;
  logic clear_err = 1'b0;
  logic up, down, dir, err;
  logic [EW-1:0] err_count;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  quadrature_decoder #(.SYNC_STAGES(S), .FILTER_LEN(FL), .ERR_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .a_in(a_in), .b_in(b_in),
    .clear_err(clear_err), .up(up), .down(down), .dir(dir), .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Position of a phase along the forward cycle 00 -> 01 -> 11 -> 10.
  function automatic int pos(input bit [1:0] ph);
    case (ph)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Model: inputs reach the decoder S edges late; step = difference in cycle position mod 4.
  bit [1:0] m_line [S];
  bit       m_track = 0;
  bit [1:0] m_last = 0;
  bit       exp_up = 0, exp_down = 0, exp_dir = 0, exp_err = 0;
  int       exp_cnt = 0;
`ifdef QDEC_FILTER_EN
  bit [1:0] m_acc = 0;
  int       m_run [2] = '{0, 0};
`endif

  always @(posedge clk or negedge reset) begin
    bit [1:0] p, sv;
    int d;
    if (!reset) begin
      for (int i = 0; i < S; i++) m_line[i] = 2'b00;
      m_track = 0; m_last = 0;
      exp_up = 0; exp_down = 0; exp_dir = 0; exp_err = 0; exp_cnt = 0;
`ifdef QDEC_FILTER_EN
      m_acc = 0; m_run[0] = 0; m_run[1] = 0;
`endif
    end else begin
      sv = m_line[S-1];
      for (int i = S - 1; i > 0; i--) m_line[i] = m_line[i-1];
      m_line[0] = {a_in, b_in};
`ifdef QDEC_FILTER_EN
      p = m_acc;
      for (int i = 0; i < 2; i++) begin
        m_run[i] = (sv[i] != m_acc[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == FL) begin
          m_acc[i] = sv[i];
          m_run[i] = 0;
        end
      end
`else
      p = sv;
`endif
      exp_up = 0; exp_down = 0;
      if (clear_err) begin exp_err = 0; exp_cnt = 0; end
      if (!enable) m_track = 0;
      else if (!m_track) begin m_track = 1; m_last = p; end
      else if (p != m_last) begin
        d = (pos(p) - pos(m_last) + 4) % 4;
        if (d == 1) begin exp_up = 1; exp_dir = 1; end
        else if (d == 3) begin exp_down = 1; exp_dir = 0; end
        else begin exp_err = 1; exp_cnt = (exp_cnt >= EMAX) ? EMAX : exp_cnt + 1; end
        m_last = p;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("up", up, exp_up);
      chk("down", down, exp_down);
      chk("dir", dir, exp_dir);
      chk("err", err, exp_err);
      chk("err_count", err_count, exp_cnt);
      chk("up_down_exclusive", up & down, 0);
    end
  end

  int n_up = 0, n_down = 0, ctr = 0;
  always @(negedge clk) begin
    if (up) begin n_up++; ctr++; end
    if (down) begin n_down++; ctr--; end
  end

  task automatic step(input bit a, input bit b, input int cyc);
    @(negedge clk);
    a_in = a; b_in = b;
    repeat (cyc - 1) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bu, bd;
    bit fa;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    chk("reset_up", up, 0);
    chk("reset_err_count", err_count, 0);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (8) @(negedge clk);
    chk("startup_no_up", n_up, 0);
    chk("startup_no_down", n_down, 0);
    chk("startup_err", err, 0);
    chk("startup_err_count", err_count, 0);

    // Re-load at 00 via INIT, which must not pulse.
    enable = 1'b0;
    a_in = 1'b0; b_in = 1'b0;
    repeat (STEP) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("reload_no_pulse", n_up + n_down, 0);

    // Forward, with exact latency on the first step.
    bu = n_up; bd = n_down;
    a_in = 1'b0; b_in = 1'b1;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    #1 chk("latency_before", up, 0);
    @(posedge clk);
    #1 chk("latency_at", up, 1);
    @(negedge clk);
    repeat (STEP) @(negedge clk);
    step(1, 1, STEP);
    step(1, 0, STEP);
    step(0, 0, STEP);
    chk("fwd_up_pulses", n_up - bu, 4);
    chk("fwd_no_down", n_down - bd, 0);
    chk("fwd_dir", dir, 1);

    // Reverse, tracked by a downstream counter starting at 100.
    bu = n_up; bd = n_down; ctr = 100;
    step(1, 0, STEP);
    step(1, 1, STEP);
    step(0, 1, STEP);
    step(0, 0, STEP);
    chk("rev_down_pulses", n_down - bd, 4);
    chk("rev_no_up", n_up - bu, 0);
    chk("rev_dir", dir, 0);
    chk("rev_counter", ctr, 96);

    // Illegal transitions.
    bu = n_up;
    step(1, 1, STEP);
    chk("illegal1_err", err, 1);
    chk("illegal1_count", err_count, 1);
    step(0, 1, STEP);
    step(1, 0, STEP);
    chk("illegal2_count", err_count, 2);
    chk("illegal_no_up", n_up - bu, 0);
    chk("illegal_dir_held", dir, 0);

    fa = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(fa, ~fa, FLIP);
      fa = ~fa;
    end
    repeat (LAT + 2) @(negedge clk);
    chk("saturate_count", err_count, EMAX);

    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_err", err, 0);
    chk("clear_count", err_count, 0);

    // Currently at 10: flip to 01 (count 1), then back to 10 colliding with clear.
    step(0, 1, STEP);
    chk("post_clear_count", err_count, 1);
    a_in = 1'b1; b_in = 1'b0;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_with_illegal_err", err, 1);
    chk("clear_with_illegal_count", err_count, 1);
    step(0, 1, STEP);

    // Disable while moving 01 -> 11, then re-enable.
    bu = n_up; bd = n_down;
    enable = 1'b0;
    step(1, 1, STEP);
    chk("disabled_no_up", n_up - bu, 0);
    enable = 1'b1;
    repeat (STEP) @(negedge clk);
    chk("reenable_no_pulse", (n_up - bu) + (n_down - bd), 0);
    chk("disable_holds_err", err_count, 2);

`ifdef QDEC_FILTER_EN
    bu = n_up; bd = n_down;
    a_in = 1'b0;
    repeat (3) @(negedge clk);
    a_in = 1'b1;
    repeat (STEP) @(negedge clk);
    chk("glitch_no_pulse", (n_up - bu) + (n_down - bd), 0);
    chk("glitch_no_err", err_count, 2);
`endif

    // Reset while a pulse is high: outputs clear before the next edge.
    a_in = 1'b1; b_in = 1'b0;
    @(posedge clk);
    repeat (LAT) @(posedge clk);
    #1 chk("pre_reset_up", up, 1);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_up", up, 0);
    chk("async_reset_dir", dir, 0);
    chk("async_reset_err", err, 0);
    chk("async_reset_count", err_count, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("after_reset_no_pulse", up | down, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
